key_repeat_sched: RTL and testbench



---
 rtl/key_repeat_sched.sv | 143 ++++++++++++++
 tb/tb_key_repeat_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_repeat_sched.sv
`default_nettype none
// ============================================================================
//  Module   : key_repeat_sched
//  Purpose  : Arbitrates N debounced key levels (lowest index wins) and emits
//             one press event for the owning key, followed after an initial
//             hold delay by periodic repeat events until the key is released.
//             All timing advances only on the prescaler tick CE.
//  Options  : KEY_RELEASE_EV_EN - when defined, KEY_REL pulses for one CLK
//             after the owner's release is detected; otherwise KEY_REL is 0.
//  Revision : 1.0 - initial release
// ============================================================================
module key_repeat_sched #(
  parameter int KEYS_NUM     = 4,
  parameter int ID_BITS      = 2,
  parameter int CNT_BITS     = 4,
  parameter int DELAY_TICKS  = 10,
  parameter int REPEAT_TICKS = 3
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                CE,
  input  logic [KEYS_NUM-1:0] KEY_LVL,
  output logic                KEY_EV,
  output logic                KEY_REP,
  output logic [ID_BITS-1:0]  KEY_ID,
  output logic                KEY_REL,
  output logic                BUSY
);

  localparam logic [1:0] c_ST_IDLE     = 2'd0;
  localparam logic [1:0] c_ST_HOLD_DLY = 2'd1;
  localparam logic [1:0] c_ST_HOLD_REP = 2'd2;

  // Reload values are "ticks minus one" so the event fires when the count hits 0.
  localparam logic [CNT_BITS-1:0] c_DELAY_LOAD  = CNT_BITS'(DELAY_TICKS - 1);
  localparam logic [CNT_BITS-1:0] c_REPEAT_LOAD = CNT_BITS'(REPEAT_TICKS - 1);
  localparam logic [CNT_BITS-1:0] c_CNT_ONE     = CNT_BITS'(1);

  logic [1:0]          r_state;
  logic [CNT_BITS-1:0] r_cnt;
  logic [ID_BITS-1:0]  r_owner;

  logic                w_any_key;
  logic [ID_BITS-1:0]  w_pick_id;
  logic                w_owner_held;
  logic                w_holding;

  // Priority encoder: scan downward so the lowest set index is the final winner.
  always_comb begin
    w_pick_id = '0;
    for (int i = KEYS_NUM - 1; i >= 0; i--) begin
      if (KEY_LVL[i]) begin
        w_pick_id = ID_BITS'(i);
      end
    end
  end

  // Level of the current owner; a compare loop keeps the select in range for
  // any KEYS_NUM, including non-powers of two.
  always_comb begin
    w_owner_held = 1'b0;
    for (int i = 0; i < KEYS_NUM; i++) begin
      if (r_owner == ID_BITS'(i)) begin
        w_owner_held = KEY_LVL[i];
      end
    end
  end

  assign w_any_key = |KEY_LVL;
  assign w_holding = (r_state == c_ST_HOLD_DLY) || (r_state == c_ST_HOLD_REP);

  // Main scheduler: ownership, hold/repeat counting and event generation.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= '0;
      r_owner <= '0;
      KEY_EV  <= 1'b0;
      KEY_REP <= 1'b0;
      KEY_ID  <= '0;
      BUSY    <= 1'b0;
    end else begin
      // Events are single-cycle pulses; only a CE edge can raise them again.
      KEY_EV <= 1'b0;
      if (CE) begin
        case (r_state)
          c_ST_IDLE: begin
            if (w_any_key) begin
              r_owner <= w_pick_id;
              KEY_ID  <= w_pick_id;
              KEY_EV  <= 1'b1;
              KEY_REP <= 1'b0;
              r_cnt   <= c_DELAY_LOAD;
              r_state <= c_ST_HOLD_DLY;
              BUSY    <= 1'b1;
            end
          end
          c_ST_HOLD_DLY,
          c_ST_HOLD_REP: begin
            // Release wins over a repeat that falls due on the same tick.
            if (!w_owner_held) begin
              r_state <= c_ST_IDLE;
              BUSY    <= 1'b0;
            end else if (r_cnt == '0) begin
              KEY_EV  <= 1'b1;
              KEY_REP <= 1'b1;
              r_cnt   <= c_REPEAT_LOAD;
              r_state <= c_ST_HOLD_REP;
            end else begin
              r_cnt <= r_cnt - c_CNT_ONE;
            end
          end
          default: begin
            r_state <= c_ST_IDLE;
            BUSY    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef KEY_RELEASE_EV_EN
  logic r_rel;

  // Release pulse: one CLK after the tick that sees the owner let go.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_rel <= 1'b0;
    end else begin
      r_rel <= CE && w_holding && !w_owner_held;
    end
  end

  assign KEY_REL = r_rel;
`else
  logic w_unused_holding;

  assign w_unused_holding = w_holding;
  assign KEY_REL          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_repeat_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_repeat_sched
//  Purpose  : Self-checking bench for key_repeat_sched. A tick-level model
//             tracks the owner and its age in CE ticks since the press and
//             derives press/repeat/release events arithmetically.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_repeat_sched;

  localparam int KEYS_NUM     = 4;
  localparam int ID_BITS      = 2;
  localparam int CNT_BITS     = 4;
  localparam int DELAY_TICKS  = 10;
  localparam int REPEAT_TICKS = 3;

  logic                clk;
  logic                clr;
  logic                ce;
  logic [KEYS_NUM-1:0] key_lvl;
  logic                key_ev;
  logic                key_rep;
  logic [ID_BITS-1:0]  key_id;
  logic                key_rel;
  logic                busy;

  int n_checks;
  int n_fail;

  // Reference model state (tick level, not clock level)
  bit m_busy;
  int m_owner;
  int m_age;
  bit m_ev;
  bit m_rep;
  int m_id;
  bit m_rel;

  key_repeat_sched #(
    .KEYS_NUM    (KEYS_NUM),
    .ID_BITS     (ID_BITS),
    .CNT_BITS    (CNT_BITS),
    .DELAY_TICKS (DELAY_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) u_dut (
    .CLK    (clk),
    .CLR    (clr),
    .CE     (ce),
    .KEY_LVL(key_lvl),
    .KEY_EV (key_ev),
    .KEY_REP(key_rep),
    .KEY_ID (key_id),
    .KEY_REL(key_rel),
    .BUSY   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_age   = 0;
    m_ev    = 1'b0;
    m_rep   = 1'b0;
    m_id    = 0;
    m_rel   = 1'b0;
  endtask

  // One CE tick of the model: press when idle, otherwise age the hold.
  task automatic model_tick(input logic [KEYS_NUM-1:0] lvl);
    if (!m_busy) begin
      if (lvl != '0) begin
        m_owner = 0;
        while (!lvl[m_owner]) m_owner++;
        m_busy = 1'b1;
        m_age  = 0;
        m_ev   = 1'b1;
        m_rep  = 1'b0;
        m_id   = m_owner;
      end
    end else begin
      m_age++;
      if (!lvl[m_owner]) begin
        m_busy = 1'b0;
`ifdef KEY_RELEASE_EV_EN
        m_rel = 1'b1;
`endif
      end else if (m_age >= DELAY_TICKS &&
                   ((m_age - DELAY_TICKS) % REPEAT_TICKS) == 0) begin
        m_ev  = 1'b1;
        m_rep = 1'b1;
      end
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".ev"},   32'(key_ev),  32'(m_ev));
    chk({where, ".rep"},  32'(key_rep), 32'(m_rep));
    chk({where, ".id"},   32'(key_id),  32'(m_id));
    chk({where, ".busy"}, 32'(busy),    32'(m_busy));
    chk({where, ".rel"},  32'(key_rel), 32'(m_rel));
  endtask

  // One clock: drive on the falling edge, check just after the rising edge.
  task automatic step(input bit ce_i, input logic [KEYS_NUM-1:0] lvl_i, input string where);
    @(negedge clk);
    ce      = ce_i;
    key_lvl = lvl_i;
    m_ev    = 1'b0;
    m_rel   = 1'b0;
    if (ce_i) model_tick(lvl_i);
    @(posedge clk);
    #1;
    check_outputs(where);
  endtask

  // One prescaler period: a CE clock followed by three idle clocks.
  task automatic tick(input logic [KEYS_NUM-1:0] lvl_i, input string where);
    step(1'b1, lvl_i, where);
    for (int j = 0; j < 3; j++) step(1'b0, lvl_i, where);
  endtask

  task automatic do_reset(input string where);
    @(negedge clk);
    clr = 1'b0;
    ce  = 1'b0;
    #1;
    model_reset();
    check_outputs({where, ".async"});
    @(posedge clk);
    #1;
    check_outputs({where, ".held"});
    @(negedge clk);
    clr = 1'b1;
  endtask

  function automatic logic [KEYS_NUM-1:0] new_pattern();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return '0;
    if (r < 7) return KEYS_NUM'(1) << $urandom_range(0, KEYS_NUM - 1);
    return KEYS_NUM'($urandom_range(1, (1 << KEYS_NUM) - 1));
  endfunction

  initial begin
    logic [KEYS_NUM-1:0] lvl;
    int gap;
    n_checks = 0;
    n_fail   = 0;
    clr      = 1'b0;
    ce       = 1'b0;
    key_lvl  = '0;
    model_reset();
    #1;
    check_outputs("reset");
    #20;
    @(negedge clk);
    clr = 1'b1;

    // Long hold of key 2: press, then repeats at ticks 10,13,16,19.
    for (int t = 0; t < 20; t++) tick(4'b0100, "long_hold");
    tick(4'b0000, "long_hold_rel");
    tick(4'b0000, "idle");

    // Release of key 3 exactly when the first repeat falls due.
    for (int t = 0; t < 10; t++) tick(4'b1000, "coinc");
    tick(4'b0000, "coinc_rel");

    // Arbitration: key 1 owns, later key 0 ignored, key 0 wins after one idle tick.
    tick(4'b1010, "arb");
    tick(4'b1010, "arb");
    for (int t = 0; t < 2; t++) tick(4'b1011, "arb_ignore");
    tick(4'b1001, "arb_rel");
    tick(4'b1001, "arb_new");
    tick(4'b0000, "arb_end");

    // CE gating mid-hold, then async reset with key still held.
    for (int t = 0; t < 5; t++) tick(4'b0001, "gate");
    for (int c = 0; c < 50; c++) step(1'b0, 4'b0001, "gate_off");
    for (int t = 0; t < 12; t++) tick(4'b0001, "gate_resume");
    do_reset("rst_mid");
    for (int t = 0; t < 4; t++) tick(4'b0001, "after_rst");
    tick(4'b0000, "after_rst_rel");

    // Randomized traffic with occasional CE gaps and resets.
    lvl = '0;
    gap = 0;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      bit ce_v;
      if ($urandom_range(0, 899) == 0) begin
        do_reset("rnd_rst");
        continue;
      end
      if (gap > 0) begin
        gap--;
        ce_v = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        gap  = 50;
        ce_v = 1'b0;
      end else begin
        ce_v = (cyc % 4) == 0;
      end
      if (ce_v && $urandom_range(0, 13) == 0) lvl = new_pattern();
      else if (!ce_v && $urandom_range(0, 79) == 0) lvl = new_pattern();
      step(ce_v, lvl, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
